step_dir_decoder: RTL and testbench
===================================

Name: step_dir_decoder

Overview:
- Receive end of the step/dir interface: samples an external step/dir pair (motor driver input tap, or a second board's generator) and reconstructs signed position and step period.
- Used for closed-loop checking of the step generator and for dead-reckoning on passive axes.
- Sits beside the step generator; the CPU/Avalon glue reads `position`, `period` and the flags.

Parameters:
- POS_W, 24, position width; matches the generator's goal/current position width.
- PER_W, 21, period counter width.
- SYNC_STAGES, 2, synchronizer flops per asynchronous input (minimum 2).
- MIN_HIGH, 100, consecutive synchronized-high cycles needed to accept a step.
- TIMEOUT, 2_000_000, cycles without an accepted step before the axis is declared stopped (must be < 2^PER_W).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset (asserted at 0, released synchronously to clk)
- step_in  input  1  asynchronous step pulse
- dir_in  input  1  asynchronous direction; 0 = count up, 1 = count down
- clear  input  1  synchronous position zero
- position  output  POS_W  accumulated position, two's complement, wraps
- period  output  PER_W  clocks between the last two accepted steps
- period_valid  output  1  `period` holds a real measurement
- moving  output  1  a step was accepted within the last TIMEOUT cycles
- step_event  output  1  one-cycle pulse on each accepted step
- glitch_count  output  8  saturating count of rejected (short) step pulses

Behaviour:
- Reset (reset = 0):
  - all outputs, synchronizer flops and counters go to 0.
  - FSM enters ARM.
- Synchronizers: step_in and dir_in each pass through SYNC_STAGES flops, giving step_s and dir_s. All logic below uses only step_s and dir_s.
- FSM states: ARM, IDLE, HIGH, WAIT_LOW.
  - ARM: go to IDLE on the first cycle step_s = 0. A pulse already high at reset release is never counted.
  - IDLE: if step_s = 1, go to HIGH with hi_cnt = 1.
  - HIGH, step_s = 1, hi_cnt = MIN_HIGH-1: accept the step, go to WAIT_LOW.
  - HIGH, step_s = 1, otherwise: hi_cnt++.
  - HIGH, step_s = 0: reject the pulse, glitch_count++ (saturates at 255), go to IDLE.
  - WAIT_LOW: go to IDLE when step_s = 0. Extra high time is ignored.
- Acceptance latency: with defaults, if step_in is first sampled high at edge 0 and stays high, acceptance registers at edge 101, i.e. SYNC_STAGES-1+MIN_HIGH.
- On acceptance (single cycle):
  - step_event = 1 for exactly that cycle.
  - position += 1 if dir_s = 0, -= 1 if dir_s = 1, modulo 2^POS_W. 0 - 1 gives all ones; all ones + 1 gives 0.
  - dir_s is sampled only in the acceptance cycle; dir changes during the pulse are irrelevant.
  - moving = 1.
- clear:
  - position = 0 on the next edge.
  - If clear coincides with acceptance, clear wins (position = 0), but step_event still pulses and period logic still runs.
- Period measurement:
  - per_cnt increments every cycle, saturating at TIMEOUT-1.
  - On acceptance: if have_prev = 1, period = per_cnt+1 and period_valid = 1. Then per_cnt = 0 and have_prev = 1.
  - First step after reset or timeout: period is unchanged, period_valid stays 0.
  - period is the exact edge-to-edge distance between acceptance cycles.
- Timeout:
  - When per_cnt reaches TIMEOUT-1 with no acceptance: moving = 0, period_valid = 0, have_prev = 0. period keeps its last value.
  - If acceptance and timeout occur in the same cycle, acceptance wins.
- Reset asserted mid-pulse: everything zeroes immediately. After release, the FSM waits in ARM until step_in has been low.

Test Plan:
- Reset release with step_in held 1, then 150-cycle low, then 200-cycle pulse, dir_in = 0 -> first pulse ignored; position = 1; step_event high exactly 1 cycle, at edge 101 after the second pulse is first sampled.
- Pulses of 99 and 100 cycles, dir_in = 0 -> 99-cycle pulse: glitch_count = 1, position unchanged; 100-cycle pulse: position +1.
- 5 pulses, 200 high, rising edges 3126 cycles apart, dir_in = 1, from position 0 -> position = 0xFFFFFB; period = 3126; period_valid = 1 after the 2nd step; moving = 1.
- Steps stop after the previous scenario; wait TIMEOUT cycles -> moving = 0 and period_valid = 0 at exactly TIMEOUT-1 cycles after the last acceptance; period still 3126; next single step leaves period_valid = 0.
- clear asserted in the acceptance cycle of a step with position = 7 -> position = 0, step_event = 1.
- 300 short 10-cycle pulses -> glitch_count saturates at 255; position unchanged; reset low mid-pulse -> all outputs 0 immediately.

Source files
------------

// File: rtl/step_dir_decoder.sv
// rtl/step_dir_decoder.sv - step/dir receiver: rebuilds signed position, step period and motion flags
module step_dir_decoder #(
  parameter int POS_W       = 24,
  parameter int PER_W       = 21,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HIGH    = 100,
  parameter int TIMEOUT     = 2_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_in,
  input  logic             dir_in,
  input  logic             clear,
  output logic [POS_W-1:0] position,
  output logic [PER_W-1:0] period,
  output logic             period_valid,
  output logic             moving,
  output logic             step_event,
  output logic [7:0]       glitch_count
);

  localparam logic [1:0] ST_ARM      = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_HIGH     = 2'd2;
  localparam logic [1:0] ST_WAIT_LOW = 2'd3;

  localparam int HI_W   = $clog2(MIN_HIGH + 1);
  localparam int FILL_W = $clog2(SYNC_STAGES + 1);

  localparam logic [HI_W-1:0]   HI_LAST  = HI_W'(MIN_HIGH - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_STAGES);
  localparam logic [PER_W-1:0]  PER_SAT  = PER_W'(TIMEOUT - 1);
  localparam logic [PER_W-1:0]  PER_PRE  = PER_W'(TIMEOUT - 2);

  logic [SYNC_STAGES-1:0] step_sync;
  logic [SYNC_STAGES-1:0] dir_sync;
  logic                   step_s;
  logic                   dir_s;
  logic [FILL_W-1:0]      fill;
  logic                   sync_primed;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [HI_W-1:0] hi_cnt;
  logic [HI_W-1:0] hi_cnt_nxt;
  logic            accept;
  logic            reject;

  logic [PER_W-1:0] per_cnt;
  logic             have_prev;
  logic             timeout_hit;

  assign step_s = step_sync[SYNC_STAGES-1];
  assign dir_s  = dir_sync[SYNC_STAGES-1];

  // The zeros flushed out of the reset synchronizer are not real samples, so ARM
  // only trusts step_s once every stage holds a post-reset sample.
  assign sync_primed = (fill == FILL_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_sync <= '0;
      dir_sync  <= '0;
      fill      <= '0;
    end else begin
      step_sync <= {step_sync[SYNC_STAGES-2:0], step_in};
      dir_sync  <= {dir_sync[SYNC_STAGES-2:0], dir_in};
      if (!sync_primed) begin
        fill <= fill + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    hi_cnt_nxt = hi_cnt;
    accept     = 1'b0;
    reject     = 1'b0;
    case (state)
      ST_ARM: begin
        if (sync_primed && !step_s) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (step_s) begin
          state_nxt  = ST_HIGH;
          hi_cnt_nxt = HI_W'(1);
        end
      end
      ST_HIGH: begin
        if (!step_s) begin
          reject    = 1'b1;
          state_nxt = ST_IDLE;
        end else if (hi_cnt == HI_LAST) begin
          accept    = 1'b1;
          state_nxt = ST_WAIT_LOW;
        end else begin
          hi_cnt_nxt = hi_cnt + 1'b1;
        end
      end
      ST_WAIT_LOW: begin
        if (!step_s) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_ARM;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_ARM;
      hi_cnt <= '0;
    end else begin
      state  <= state_nxt;
      hi_cnt <= hi_cnt_nxt;
    end
  end

  // Fires on the edge where per_cnt lands on TIMEOUT-1, so the flags drop
  // exactly TIMEOUT-1 cycles after the last accepted step.
  assign timeout_hit = !accept && (per_cnt == PER_PRE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      position     <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      moving       <= 1'b0;
      step_event   <= 1'b0;
      glitch_count <= '0;
      per_cnt      <= '0;
      have_prev    <= 1'b0;
    end else begin
      step_event <= accept;

      if (clear) begin
        position <= '0;
      end else if (accept) begin
        position <= dir_s ? position - 1'b1 : position + 1'b1;
      end

      if (reject && glitch_count != 8'hFF) begin
        glitch_count <= glitch_count + 1'b1;
      end

      if (accept) begin
        per_cnt <= '0;
      end else if (per_cnt != PER_SAT) begin
        per_cnt <= per_cnt + 1'b1;
      end

      if (accept) begin
        if (have_prev) begin
          period       <= per_cnt + 1'b1;
          period_valid <= 1'b1;
        end
        have_prev <= 1'b1;
        moving    <= 1'b1;
      end else if (timeout_hit) begin
        have_prev    <= 1'b0;
        moving       <= 1'b0;
        period_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_step_dir_decoder.sv
// tb/tb_step_dir_decoder.sv - directed bench with a pulse-level reference model for step_dir_decoder
module tb_step_dir_decoder;

  localparam int POS_W    = 24;
  localparam int PER_W    = 21;
  localparam int SYNC     = 2;
  localparam int MIN_HIGH = 100;
  localparam int TIMEOUT  = 5000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             step_in = 1'b0;
  logic             dir_in = 1'b0;
  logic             clear = 1'b0;
  logic [POS_W-1:0] position;
  logic [PER_W-1:0] period;
  logic             period_valid;
  logic             moving;
  logic             step_event;
  logic [7:0]       glitch_count;

  always #5 clk = ~clk;

  step_dir_decoder #(
    .POS_W(POS_W), .PER_W(PER_W), .SYNC_STAGES(SYNC),
    .MIN_HIGH(MIN_HIGH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .step_in(step_in), .dir_in(dir_in), .clear(clear),
    .position(position), .period(period), .period_valid(period_valid),
    .moving(moving), .step_event(step_event), .glitch_count(glitch_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: synchronized samples as a delay queue, pulses as run lengths,
  // period and timeout from edge timestamps of accepted steps.
  logic [POS_W-1:0] m_pos;
  logic [PER_W-1:0] m_period;
  logic             m_pv, m_moving, m_event;
  logic [7:0]       m_glitch;
  int               m_run;
  logic             m_armed, m_parmed, m_have_acc;
  longint           m_edge, m_last;
  logic             sq[$];
  logic             dq[$];

  always @(posedge clk or negedge reset) begin : model
    logic   sv, s, d, acc, gl, armed_n, parmed_n;
    int     run_n;
    longint gap;
    if (!reset) begin
      sq.delete();
      dq.delete();
      m_pos <= '0; m_period <= '0; m_pv <= 1'b0; m_moving <= 1'b0; m_event <= 1'b0;
      m_glitch <= '0; m_run <= 0; m_armed <= 1'b0; m_parmed <= 1'b0;
      m_have_acc <= 1'b0; m_edge <= 0; m_last <= 0;
    end else begin
      sv = (sq.size() == SYNC);
      s  = sv ? sq[0] : 1'b0;
      d  = sv ? dq[0] : 1'b0;
      sq.push_back(step_in);
      dq.push_back(dir_in);
      if (sq.size() > SYNC) begin
        sq.pop_front();
        dq.pop_front();
      end
      acc = 1'b0; gl = 1'b0;
      run_n = m_run; armed_n = m_armed; parmed_n = m_parmed;
      if (sv) begin
        if (s) begin
          if (run_n == 0) parmed_n = armed_n;
          run_n++;
          if (parmed_n && run_n == MIN_HIGH) acc = 1'b1;
        end else begin
          if (parmed_n && run_n > 0 && run_n < MIN_HIGH) gl = 1'b1;
          run_n = 0;
          armed_n = 1'b1;
        end
      end
      m_run <= run_n; m_armed <= armed_n; m_parmed <= parmed_n;
      m_event <= acc;
      if (gl && m_glitch != 8'd255) m_glitch <= m_glitch + 8'd1;
      m_pos <= clear ? '0 : (acc ? (d ? m_pos - 1'b1 : m_pos + 1'b1) : m_pos);
      gap = m_edge - m_last;
      if (acc) begin
        if (m_have_acc && gap <= TIMEOUT - 1) begin
          m_period <= PER_W'(gap);
          m_pv     <= 1'b1;
        end
        m_last     <= m_edge;
        m_have_acc <= 1'b1;
        m_moving   <= 1'b1;
      end else if (m_have_acc && gap >= TIMEOUT - 1) begin
        m_moving <= 1'b0;
        m_pv     <= 1'b0;
      end
      m_edge <= m_edge + 1;
    end
  end

  always begin
    @(posedge clk);
    #3;
    chk("cmp_position", 32'(position), 32'(m_pos));
    chk("cmp_period", 32'(period), 32'(m_period));
    chk("cmp_period_valid", 32'(period_valid), 32'(m_pv));
    chk("cmp_moving", 32'(moving), 32'(m_moving));
    chk("cmp_step_event", 32'(step_event), 32'(m_event));
    chk("cmp_glitch_count", 32'(glitch_count), 32'(m_glitch));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    step_in = 1'b1;
    cyc(hi);
    step_in = 1'b0;
    cyc(lo);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_position"}, 32'(position), 32'd0);
    chk({tag, "_period"}, 32'(period), 32'd0);
    chk({tag, "_period_valid"}, 32'(period_valid), 32'd0);
    chk({tag, "_moving"}, 32'(moving), 32'd0);
    chk({tag, "_step_event"}, 32'(step_event), 32'd0);
    chk({tag, "_glitch"}, 32'(glitch_count), 32'd0);
  endtask

  initial begin
    int ev_cnt;
    int ev_at;
    int found;

    // Reset with step_in already high; that pulse must never count.
    #1 reset = 1'b0;
    step_in = 1'b1;
    cyc(3);
    chk_all_zero("reset");
    reset = 1'b1;
    cyc(50);
    step_in = 1'b0;
    cyc(150);
    chk("s1_held_pulse_pos", 32'(position), 32'd0);
    chk("s1_held_pulse_glitch", 32'(glitch_count), 32'd0);

    step_in = 1'b1;
    ev_cnt = 0;
    ev_at = -1;
    for (int j = 1; j <= 200; j++) begin
      cyc(1);
      if (step_event) begin
        ev_cnt++;
        if (ev_at < 0) ev_at = j - 1;
      end
    end
    chk("s1_event_edge", 32'(ev_at), 32'd101);
    chk("s1_event_count", 32'(ev_cnt), 32'd1);
    step_in = 1'b0;
    cyc(150);
    chk("s1_position", 32'(position), 32'd1);

    // Boundary pulse widths.
    pulse(99, 150);
    chk("s2_glitch_99", 32'(glitch_count), 32'd1);
    chk("s2_pos_99", 32'(position), 32'd1);
    pulse(100, 150);
    chk("s2_pos_100", 32'(position), 32'd2);

    cyc(TIMEOUT);
    chk("s2_timeout_moving", 32'(moving), 32'd0);

    // Five down steps, 3126 cycles apart.
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    dir_in = 1'b1;
    cyc(5);
    chk("s3_cleared", 32'(position), 32'd0);
    pulse(200, 2926);
    chk("s3_first_pv", 32'(period_valid), 32'd0);
    chk("s3_first_moving", 32'(moving), 32'd1);
    chk("s3_first_pos", 32'(position), 32'hFFFFFF);
    pulse(200, 2926);
    chk("s3_second_pv", 32'(period_valid), 32'd1);
    chk("s3_second_period", 32'(period), 32'd3126);
    pulse(200, 2926);
    pulse(200, 2926);

    step_in = 1'b1;
    found = 0;
    for (int j = 0; j < 300; j++) begin
      cyc(1);
      if (step_event) begin
        found = 1;
        break;
      end
    end
    chk("s3_fifth_accept_seen", 32'(found), 32'd1);
    chk("s3_pos", 32'(position), 32'hFFFFFB);
    chk("s3_model_pos", 32'(m_pos), 32'hFFFFFB);
    chk("s3_period", 32'(period), 32'd3126);
    chk("s3_model_period", 32'(m_period), 32'd3126);

    // Timeout lands exactly TIMEOUT-1 cycles after the last acceptance.
    for (int k = 1; k <= TIMEOUT - 1; k++) begin
      cyc(1);
      if (k == 99) step_in = 1'b0;
      if (k == TIMEOUT - 2) begin
        chk("s4_moving_before", 32'(moving), 32'd1);
        chk("s4_pv_before", 32'(period_valid), 32'd1);
      end
    end
    chk("s4_moving_after", 32'(moving), 32'd0);
    chk("s4_pv_after", 32'(period_valid), 32'd0);
    chk("s4_period_kept", 32'(period), 32'd3126);
    pulse(200, 300);
    chk("s4_restart_pv", 32'(period_valid), 32'd0);
    chk("s4_restart_moving", 32'(moving), 32'd1);
    chk("s4_restart_period", 32'(period), 32'd3126);
    chk("s4_restart_pos", 32'(position), 32'hFFFFFA);

    // clear coinciding with acceptance.
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    dir_in = 1'b0;
    repeat (7) pulse(100, 110);
    chk("s5_pos_seven", 32'(position), 32'd7);
    step_in = 1'b1;
    cyc(101);
    clear = 1'b1;
    cyc(1);
    chk("s5_event", 32'(step_event), 32'd1);
    chk("s5_pos_cleared", 32'(position), 32'd0);
    clear = 1'b0;
    cyc(1);
    chk("s5_event_drop", 32'(step_event), 32'd0);
    step_in = 1'b0;
    cyc(150);

    // Glitch saturation, then reset mid-pulse.
    pulse(100, 110);
    repeat (300) pulse(10, 10);
    chk("s6_glitch_sat", 32'(glitch_count), 32'd255);
    chk("s6_pos_kept", 32'(position), 32'd1);
    step_in = 1'b1;
    cyc(50);
    reset = 1'b0;
    #1;
    chk_all_zero("s6_async_reset");
    cyc(5);
    reset = 1'b1;
    cyc(200);
    chk("s6_rearm_pos", 32'(position), 32'd0);
    step_in = 1'b0;
    cyc(50);
    pulse(150, 150);
    chk("s6_after_reset_pos", 32'(position), 32'd1);
    chk("s6_after_reset_glitch", 32'(glitch_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
